// File: rtl/int2float_pipe.sv
// int2float_pipe: four-stage integer to IEEE-754 single-precision converter.
// Round-to-nearest-even, valid qualifier travelling with the data, clock
// enable freezing every stage, synchronous active-high clear.
// Optional feature: define INT2FLOAT_INEXACT_EN to add the inexact output.
module int2float_pipe #(
    parameter int W      = 32,
    parameter int SIGNED = 1
) (
    input  logic         clock,
    input  logic         sclr,
    input  logic         clk_en,
    input  logic         valid_in,
    input  logic [W-1:0] dataa,
    output logic         valid_out,
    output logic [31:0]  result,
    output logic         zero
`ifdef INT2FLOAT_INEXACT_EN
    ,
    output logic         inexact
`endif
);

    localparam int PW = $clog2(W);
    localparam int FW = W - 1;
    localparam logic [PW-1:0] TOP = PW'(W - 1);

    logic          r_v1, r_sign1;
    logic [W-1:0]  r_mag1;
    logic          r_v2, r_sign2, r_zero2;
    logic [W-1:0]  r_mag2;
    logic [PW-1:0] r_p2;
    logic          r_v3, r_sign3, r_zero3;
    logic [FW-1:0] r_frac3;
    logic [PW-1:0] r_p3;
    logic          r_v4, r_zero4;
    logic [31:0]   r_result4;

    logic          w_neg;
    logic [W-1:0]  w_mag;
    logic [PW-1:0] w_p;
    logic [22:0]   w_mant;
    logic          w_guard, w_sticky, w_inc;
    logic [23:0]   w_mant_r;
    logic [7:0]    w_exp;

    // Stage 1 input: negate two's-complement negatives; -2^(W-1) maps to 2^(W-1)
    assign w_neg = (SIGNED != 0) & dataa[W-1];
    assign w_mag = w_neg ? (-dataa) : dataa;

    // Stage 1: capture sign and magnitude
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag1  <= '0;
        end else if (clk_en) begin
            r_v1    <= valid_in;
            r_sign1 <= w_neg;
            r_mag1  <= w_mag;
        end
    end

    // Leading-one priority encoder; highest set bit wins
    always_comb begin
        w_p = '0;
        for (int i = 0; i < W; i++) begin
            if (r_mag1[i]) w_p = PW'(i);
        end
    end

    // Stage 2: capture leading-one position and zero flag
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_zero2 <= 1'b0;
            r_mag2  <= '0;
            r_p2    <= '0;
        end else if (clk_en) begin
            r_v2    <= r_v1;
            r_sign2 <= r_sign1;
            r_zero2 <= (r_mag1 == '0);
            r_mag2  <= r_mag1;
            r_p2    <= w_p;
        end
    end

    // Stage 3: left-normalise; the implicit leading one is dropped, only the fraction is kept
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_v3    <= 1'b0;
            r_sign3 <= 1'b0;
            r_zero3 <= 1'b0;
            r_frac3 <= '0;
            r_p3    <= '0;
        end else if (clk_en) begin
            r_v3    <= r_v2;
            r_sign3 <= r_sign2;
            r_zero3 <= r_zero2;
            r_frac3 <= FW'(r_mag2 << (TOP - r_p2));
            r_p3    <= r_p2;
        end
    end

    // Fraction split into mantissa, guard and sticky; rounding exists only for W > 24
    generate
        if (FW <= 23) begin : g_exact
            assign w_mant   = 23'(r_frac3) << (23 - FW);
            assign w_guard  = 1'b0;
            assign w_sticky = 1'b0;
        end else if (FW == 24) begin : g_round_guard
            assign w_mant   = r_frac3[23:1];
            assign w_guard  = r_frac3[0];
            assign w_sticky = 1'b0;
        end else begin : g_round
            assign w_mant   = r_frac3[FW-1 -: 23];
            assign w_guard  = r_frac3[FW-24];
            assign w_sticky = |r_frac3[FW-25:0];
        end
    endgenerate

    // Round to nearest even; a mantissa carry bumps the exponent and leaves the mantissa zero
    assign w_inc    = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_r = {1'b0, w_mant} + {23'd0, w_inc};
    assign w_exp    = 8'd127 + 8'(r_p3) + {7'd0, w_mant_r[23]};

    // Stage 4: pack; zero input forces +0.0
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_v4      <= 1'b0;
            r_zero4   <= 1'b0;
            r_result4 <= '0;
        end else if (clk_en) begin
            r_v4      <= r_v3;
            r_zero4   <= r_zero3;
            r_result4 <= r_zero3 ? 32'h0000_0000 : {r_sign3, w_exp, w_mant_r[22:0]};
        end
    end

`ifdef INT2FLOAT_INEXACT_EN
    logic r_inexact4;

    // Stage 4 inexact: any discarded bit below the mantissa
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_inexact4 <= 1'b0;
        end else if (clk_en) begin
            r_inexact4 <= w_guard | w_sticky;
        end
    end

    assign inexact = r_inexact4;
`endif

    assign valid_out = r_v4;
    assign result    = r_result4;
    assign zero      = r_zero4;

endmodule

// File: tb/tb_int2float_pipe.sv
// Testbench for int2float_pipe: four instances (32 signed, 32 unsigned,
// 16 signed, 64 unsigned), scoreboard queues filled at issue time and a
// negedge monitor that pops and compares whenever valid_out is seen.
module tb_int2float_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ix;
        logic [31:0] due;
    } exp_t;

    logic             clock;
    logic             sclr;
    logic             clk_en;
    logic [3:0]       vin;
    logic [31:0]      a0, a1;
    logic [15:0]      a2;
    logic [63:0]      a3;
    logic [3:0]       vo, zr, ix;
    logic [3:0][31:0] rs;

    logic [3:0]       pvo;
    logic [3:0][31:0] prs;

    exp_t q0[$], q1[$], q2[$], q3[$];

    int n_cmp = 0;
    int n_err = 0;
    int adv_cnt = 0;
    bit last_adv = 1'b0;
    bit last_rst = 1'b1;

    int2float_pipe #(.W(32), .SIGNED(1)) u_s32 (
        .clock(clock), .sclr(sclr), .clk_en(clk_en), .valid_in(vin[0]), .dataa(a0),
        .valid_out(vo[0]), .result(rs[0]), .zero(zr[0])
`ifdef INT2FLOAT_INEXACT_EN
        , .inexact(ix[0])
`endif
    );

    int2float_pipe #(.W(32), .SIGNED(0)) u_u32 (
        .clock(clock), .sclr(sclr), .clk_en(clk_en), .valid_in(vin[1]), .dataa(a1),
        .valid_out(vo[1]), .result(rs[1]), .zero(zr[1])
`ifdef INT2FLOAT_INEXACT_EN
        , .inexact(ix[1])
`endif
    );

    int2float_pipe #(.W(16), .SIGNED(1)) u_s16 (
        .clock(clock), .sclr(sclr), .clk_en(clk_en), .valid_in(vin[2]), .dataa(a2),
        .valid_out(vo[2]), .result(rs[2]), .zero(zr[2])
`ifdef INT2FLOAT_INEXACT_EN
        , .inexact(ix[2])
`endif
    );

    int2float_pipe #(.W(64), .SIGNED(0)) u_u64 (
        .clock(clock), .sclr(sclr), .clk_en(clk_en), .valid_in(vin[3]), .dataa(a3),
        .valid_out(vo[3]), .result(rs[3]), .zero(zr[3])
`ifdef INT2FLOAT_INEXACT_EN
        , .inexact(ix[3])
`endif
    );

`ifndef INT2FLOAT_INEXACT_EN
    assign ix = '0;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Independent reference for 16-bit signed inputs (always exact)
    function automatic logic [31:0] ref16(input int v);
        int   m;
        int   p;
        logic s;
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 17; i++) if (m >= (1 << i)) p = i;
        return {s, 8'(127 + p), 23'((m - (1 << p)) << (23 - p))};
    endfunction

    // Drive one operand on instance d for one advancing cycle; expected result due 4 advances later
    task automatic send(input int d, input logic [63:0] a, input logic [31:0] r,
                        input logic z, input logic x);
        exp_t e;
        case (d)
            0: a0 = a[31:0];
            1: a1 = a[31:0];
            2: a2 = a[15:0];
            default: a3 = a;
        endcase
        vin[d] = 1'b1;
        e.res  = r;
        e.z    = z;
        e.ix   = x;
        e.due  = 32'(adv_cnt + 4);
        push(d, e);
        @(negedge clock);
        vin[d] = 1'b0;
    endtask

    always @(posedge clock) begin
        last_adv = clk_en & ~sclr;
        last_rst = sclr;
        if (last_adv) adv_cnt++;
    end

    // Monitor: new outputs after advancing edges are popped and compared; stalled edges must hold
    always @(negedge clock) begin : mon
        exp_t e;
        bit   ok;
        for (int d = 0; d < 4; d++) begin
            if (!last_rst) begin
                if (last_adv) begin
                    if (vo[d]) begin
                        pop(d, e, ok);
                        if (!ok) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL dut%0d unexpected output: got result 0x%0h, expected no valid_out", d, rs[d]);
                        end else begin
                            chk($sformatf("dut%0d latency", d), 64'(adv_cnt), 64'(e.due));
                            chk($sformatf("dut%0d result", d), 64'(rs[d]), 64'(e.res));
                            chk($sformatf("dut%0d zero", d), 64'(zr[d]), 64'(e.z));
`ifdef INT2FLOAT_INEXACT_EN
                            chk($sformatf("dut%0d inexact", d), 64'(ix[d]), 64'(e.ix));
`endif
                        end
                    end
                end else begin
                    chk($sformatf("dut%0d stall hold valid_out", d), 64'(vo[d]), 64'(pvo[d]));
                    chk($sformatf("dut%0d stall hold result", d), 64'(rs[d]), 64'(prs[d]));
                end
            end
            pvo[d] = vo[d];
            prs[d] = rs[d];
        end
    end

    logic [63:0] sv[5] = '{64'd1000000, 64'd2, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7};
    logic [31:0] sr[5] = '{32'h4974_2400, 32'h4000_0000, 32'h40A0_0000, 32'hC000_0000, 32'h40E0_0000};

    initial begin
        sclr   = 1'b1;
        clk_en = 1'b1;
        vin    = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        repeat (3) @(negedge clock);

        for (int d = 0; d < 4; d++) begin
            chk($sformatf("dut%0d reset valid_out", d), 64'(vo[d]), 64'd0);
            chk($sformatf("dut%0d reset result", d), 64'(rs[d]), 64'd0);
            chk($sformatf("dut%0d reset zero", d), 64'(zr[d]), 64'd0);
`ifdef INT2FLOAT_INEXACT_EN
            chk($sformatf("dut%0d reset inexact", d), 64'(ix[d]), 64'd0);
`endif
        end
        sclr = 1'b0;

        // Continuous stream on 32-bit signed
        send(0, 64'd0, 32'h0000_0000, 1'b1, 1'b0);
        send(0, 64'd1, 32'h3F80_0000, 1'b0, 1'b0);
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0);
        send(0, 64'd3, 32'h4040_0000, 1'b0, 1'b0);
        send(0, 64'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0);
        send(0, 64'h7FFF_FFFF, 32'h4F00_0000, 1'b0, 1'b1);
        send(0, 64'd1000000, 32'h4974_2400, 1'b0, 1'b0);

        // Rounding on 32-bit unsigned
        send(1, 64'hFFFF_FFFF, 32'h4F80_0000, 1'b0, 1'b1);
        send(1, 64'd16777217, 32'h4B80_0000, 1'b0, 1'b1);
        send(1, 64'd16777219, 32'h4B80_0002, 1'b0, 1'b1);
        send(1, 64'd16777216, 32'h4B80_0000, 1'b0, 1'b0);
        send(1, 64'd16777218, 32'h4B80_0001, 1'b0, 1'b0);
        send(1, 64'h8000_0000, 32'h4F00_0000, 1'b0, 1'b0);

        // 64-bit unsigned extremes
        send(3, 64'h8000_0000_0000_0000, 32'h5F00_0000, 1'b0, 1'b0);
        send(3, 64'hFFFF_FFFF_FFFF_FFFF, 32'h5F80_0000, 1'b0, 1'b1);
        send(3, 64'd0, 32'h0000_0000, 1'b1, 1'b0);

        // 16-bit signed: most negative value, then exhaustive sweep
        send(2, 64'hFFFF_FFFF_FFFF_8000, 32'hC700_0000, 1'b0, 1'b0);
        for (int v = -32768; v < 32768; v++) begin
            send(2, 64'(v), ref16(v), (v == 0), 1'b0);
        end
        repeat (6) @(negedge clock);

        // Stall: clk_en pattern 1,0,0 per operand
        for (int k = 0; k < 5; k++) begin
            clk_en = 1'b1;
            send(0, sv[k], sr[k], 1'b0, 1'b0);
            clk_en = 1'b0;
            repeat (2) @(negedge clock);
        end
        clk_en = 1'b1;
        repeat (6) @(negedge clock);

        // Reset with three operations in flight: none of them may emerge
        send(0, 64'd2, 32'h4000_0000, 1'b0, 1'b0);
        send(0, 64'd5, 32'h40A0_0000, 1'b0, 1'b0);
        send(0, 64'd7, 32'h40E0_0000, 1'b0, 1'b0);
        q0.delete();
        sclr = 1'b1;
        @(negedge clock);
        chk("inflight reset valid_out", 64'(vo[0]), 64'd0);
        chk("inflight reset result", 64'(rs[0]), 64'd0);
        sclr = 1'b0;
        repeat (8) @(negedge clock);

        // Recovery after reset
        send(0, 64'd100, 32'h42C8_0000, 1'b0, 1'b0);
        repeat (6) @(negedge clock);

        chk("dut0 leftover expected", 64'(q0.size()), 64'd0);
        chk("dut1 leftover expected", 64'(q1.size()), 64'd0);
        chk("dut2 leftover expected", 64'(q2.size()), 64'd0);
        chk("dut3 leftover expected", 64'(q3.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
